stp_fsm: RTL and testbench

STP_FSM -- requirements
Module: stp_fsm

---
 rtl/stp_fsm.sv | 89 ++++++++
 tb/tb_stp_fsm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stp_fsm.sv
// Polynomial loader: copies N+1 coefficients from the data buffer into the
// coefficient RAM slot A*11.., then records the degree in the degree RAM.
module stp_fsm #(
  parameter  int buffer_size = 1024,
  localparam int AW          = (buffer_size > 1) ? $clog2(buffer_size) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_stp,
  input  logic [2:0]    A,
  input  logic [4:0]    N_in,
  input  logic [AW-1:0] rd_addr_data,
  input  logic [15:0]   ram_out_data,
  output logic          en_rd_data,
  output logic [AW-1:0] rd_addr_data_updated,
  output logic          en_wr_S,
  output logic [6:0]    wr_addr_S,
  output logic [15:0]   wr_data_S,
  output logic          en_wr_N,
  output logic [2:0]    wr_addr_N,
  output logic [4:0]    wr_data_N,
  output logic          done_stp,
  output logic [31:0]   status
);

  typedef enum logic [2:0] {
    ST_START, ST_CHECK_N, ST_RD, ST_WR, ST_WR_N, ST_ERR, ST_END
  } state_t;

  localparam logic [AW-1:0] PTR_LAST = AW'(buffer_size - 1);

  state_t      state;
  logic [2:0]  a_q;
  logic [4:0]  n_q;
  logic [3:0]  idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                <= ST_START;
      rd_addr_data_updated <= '0;
      idx                  <= '0;
      status               <= 32'hFFFF_FFFF;
      a_q                  <= '0;
      n_q                  <= '0;
    end else begin
      case (state)
        ST_START: if (start_stp) begin
          a_q                  <= A;
          n_q                  <= N_in;
          rd_addr_data_updated <= rd_addr_data;
          idx                  <= '0;
          state                <= ST_CHECK_N;
        end
        ST_CHECK_N: state <= (n_q > 5'd10) ? ST_ERR : ST_RD;
        ST_RD:      state <= ST_WR;
        ST_WR: begin
          idx                  <= idx + 4'd1;
          // Pointer wraps explicitly so non-power-of-two buffers work too
          rd_addr_data_updated <= (rd_addr_data_updated == PTR_LAST) ? '0
                                  : rd_addr_data_updated + AW'(1);
          state                <= ({1'b0, idx} == n_q) ? ST_WR_N : ST_RD;
        end
        ST_WR_N: begin
          status <= 32'd0;
          state  <= ST_END;
        end
        ST_ERR: begin
          status <= 32'd2;
          state  <= ST_END;
        end
        ST_END:  state <= ST_START;
        default: state <= ST_START;
      endcase
    end
  end

  // Strobes are pure state decodes; address/data are zeroed while idle
  assign en_rd_data = (state == ST_RD);
  assign en_wr_S    = (state == ST_WR);
  assign en_wr_N    = (state == ST_WR_N) || (state == ST_ERR);
  assign done_stp   = (state == ST_END);

  assign wr_addr_S = en_wr_S ? (7'(a_q) * 7'd11 + 7'(idx)) : 7'd0;
  assign wr_data_S = en_wr_S ? ram_out_data : 16'd0;
  assign wr_addr_N = en_wr_N ? a_q : 3'd0;
  assign wr_data_N = (state == ST_ERR)  ? 5'h1F :
                     (state == ST_WR_N) ? n_q   : 5'd0;

endmodule

// File: tb/tb_stp_fsm.sv
// Scoreboard bench for stp_fsm: expected RAM writes are queued at command
// time and popped as the DUT issues them; latency and status checked at done.
module tb_stp_fsm;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_stp = 1'b0;
  logic [2:0]    A = '0;
  logic [4:0]    N_in = '0;
  logic [AW-1:0] rd_addr_data = '0;
  logic [15:0]   ram_out_data = '0;
  logic          en_rd_data, en_wr_S, en_wr_N, done_stp;
  logic [AW-1:0] rd_addr_data_updated;
  logic [6:0]    wr_addr_S;
  logic [15:0]   wr_data_S;
  logic [2:0]    wr_addr_N;
  logic [4:0]    wr_data_N;
  logic [31:0]   status;

  stp_fsm #(.buffer_size(1024)) dut (
    .clk(clk), .rst(rst), .start_stp(start_stp), .A(A), .N_in(N_in),
    .rd_addr_data(rd_addr_data), .ram_out_data(ram_out_data),
    .en_rd_data(en_rd_data), .rd_addr_data_updated(rd_addr_data_updated),
    .en_wr_S(en_wr_S), .wr_addr_S(wr_addr_S), .wr_data_S(wr_data_S),
    .en_wr_N(en_wr_N), .wr_addr_N(wr_addr_N), .wr_data_N(wr_data_N),
    .done_stp(done_stp), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] a; logic [15:0] d; } s_wr_t;
  typedef struct { logic [2:0] a; logic [4:0] d; } n_wr_t;

  s_wr_t       exp_s[$];
  n_wr_t       exp_n[$];
  logic [15:0] bufm[1024];
  int          cyc = 0, exp_done = -1, done_cnt = 0, s_wr_cnt = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (en_rd_data) ram_out_data <= bufm[rd_addr_data_updated];

  always @(negedge clk) begin
    s_wr_t s; n_wr_t n;
    if (en_wr_S === 1'b1) begin
      s_wr_cnt++;
      if (exp_s.size() == 0) chk("s_unexpected_wr", en_wr_S, 0);
      else begin
        s = exp_s.pop_front();
        chk("s_addr", wr_addr_S, s.a);
        chk("s_data", wr_data_S, s.d);
      end
    end
    if (en_wr_N === 1'b1) begin
      if (exp_n.size() == 0) chk("n_unexpected_wr", en_wr_N, 0);
      else begin
        n = exp_n.pop_front();
        chk("n_addr", wr_addr_N, n.a);
        chk("n_data", wr_data_N, n.d);
      end
    end
    if (done_stp === 1'b1) begin
      done_cnt++;
      chk("done_latency", cyc, exp_done);
    end
  end

  task automatic load(input logic [2:0] a, input logic [4:0] n, input int base,
                      input bit mid_start);
    int dc0;
    int exp_ptr;
    logic [31:0] exp_st;
    if (n <= 10) begin
      for (int i = 0; i <= n; i++)
        exp_s.push_back('{a: 7'(a * 11 + i), d: bufm[(base + i) % 1024]});
      exp_n.push_back('{a: a, d: n});
      exp_st  = 0;
      exp_ptr = (base + n + 1) % 1024;
    end else begin
      exp_n.push_back('{a: a, d: 5'h1F});
      exp_st  = 2;
      exp_ptr = base;
    end
    @(negedge clk); #1;
    A = a; N_in = n; rd_addr_data = AW'(base); start_stp = 1'b1;
    exp_done = (n <= 10) ? cyc + 2 * n + 5 : cyc + 3;
    dc0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_cnt != dc0) break;
      if (mid_start && i == 3) begin start_stp = 1'b1; A = a + 3'd1; end
      else start_stp = 1'b0;
    end
    start_stp = 1'b0;
    chk("done_count", done_cnt - dc0, 1);
    chk("status", status, exp_st);
    chk("rd_ptr", rd_addr_data_updated, exp_ptr);
    @(negedge clk); #1;
    chk("done_one_cycle", done_stp, 0);
    chk("s_pending", exp_s.size(), 0);
    chk("n_pending", exp_n.size(), 0);
    exp_s.delete(); exp_n.delete();
    exp_done = -1;
  endtask

  task automatic abort_load(input logic [2:0] a, input int base);
    int w0, dc0;
    for (int i = 0; i < 3; i++)
      exp_s.push_back('{a: 7'(a * 11 + i), d: bufm[(base + i) % 1024]});
    w0 = s_wr_cnt; dc0 = done_cnt;
    @(negedge clk); #1;
    A = a; N_in = 5'd5; rd_addr_data = AW'(base); start_stp = 1'b1;
    @(negedge clk); #1; start_stp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_wr_cnt - w0 >= 3) break;
      @(negedge clk); #1;
    end
    chk("abort_reached_wr3", s_wr_cnt - w0, 3);
    rst = 1'b0;
    @(negedge clk); #1; rst = 1'b1;
    chk("abort_status", status, 32'hFFFF_FFFF);
    chk("abort_ptr", rd_addr_data_updated, 0);
    chk("abort_enables", {en_rd_data, en_wr_S, en_wr_N, done_stp}, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_s_pending", exp_s.size(), 0);
    exp_s.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bufm[i] = 16'($urandom);
    bufm[100] = 16'd5; bufm[101] = 16'd6; bufm[102] = 16'd7; bufm[103] = 16'd8;
    repeat (3) @(negedge clk);
    chk("rst_status", status, 32'hFFFF_FFFF);
    chk("rst_ptr", rd_addr_data_updated, 0);
    chk("rst_enables", {en_rd_data, en_wr_S, en_wr_N, done_stp}, 0);
    chk("rst_idle_outs", {wr_addr_S, wr_data_S, wr_addr_N, wr_data_N}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    load(3'd2, 5'd3, 100, 1'b0);
    load(3'd7, 5'd10, 0, 1'b0);
    load(3'd1, 5'd0, 37, 1'b0);
    load(3'd1, 5'd11, 40, 1'b0);
    load(3'd0, 5'd31, 600, 1'b0);
    load(3'd5, 5'd2, 1022, 1'b0);
    load(3'd4, 5'd4, 500, 1'b1);
    abort_load(3'd3, 200);
    chk("idle_outs", {wr_addr_S, wr_data_S, wr_addr_N, wr_data_N}, 0);
    for (int k = 0; k < 6; k++)
      load(3'($urandom_range(0, 7)), 5'($urandom_range(0, 12)),
           int'($urandom_range(0, 1023)), 1'(k & 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
